// File: rtl/data_mem_pkg.sv
// Shared types, size codes and lane-strobe helpers for the CPU/DMA data memory.
package data_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int ARB_CPU_PRIO = 0;
    localparam int ARB_RR       = 1;

    localparam int MAX_BYTES = 64;

    typedef struct packed {
        logic [MAX_BYTES-1:0] p0;
        logic [MAX_BYTES-1:0] p1;
    } lane_mask_t;

    // The illegal size code behaves as a word; never wider than one memory word.
    function automatic int size_bytes(input logic [1:0] sz, input int bytes);
        int nb;
        nb = (sz == 2'd3) ? 4 : (1 << sz);
        if (nb > bytes) nb = bytes;
        return nb;
    endfunction

    // p0: lanes touched in word n; p1: lanes spilling into word n+1.
    function automatic lane_mask_t lane_masks(input int bytes, input int off, input int nb);
        lane_mask_t m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            m.p0[i] = (i >= off) && (i < off + nb) && (i < bytes);
            m.p1[i] = (i < off + nb - bytes);
        end
        return m;
    endfunction

endpackage

// File: rtl/data_mem_arb_if.sv
// CPU load/store and DMA port bundle of the shared data memory.
interface data_mem_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // CPU: cpu_req and its fields stay stable until data_mem_hazard is low at a
    // clock edge (that edge completes the access). DMA: an access happens at each
    // edge where dma_req and dma_gnt are both high. Read data is qualified by a
    // single-cycle rvalid pulse on each port; there is no back-pressure on reads.
    logic                  cpu_req;
    logic                  cpu_we;
    logic [1:0]            cpu_size;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_rvalid;
    logic                  cpu_err;
    logic                  data_mem_hazard;
    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic                  dma_gnt;
    logic [DATA_WIDTH-1:0] dma_rdata;
    logic                  dma_rvalid;

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  cpu_rdata, cpu_rvalid, cpu_err, data_mem_hazard,
        input  dma_gnt, dma_rdata, dma_rvalid
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output cpu_rdata, cpu_rvalid, cpu_err, data_mem_hazard,
        output dma_gnt, dma_rdata, dma_rvalid
    );

endinterface

// File: rtl/data_mem_bank.sv
// Single-port byte-strobed RAM with a registered (one-cycle) read port.
module data_mem_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [DATA_WIDTH/8-1:0]      strb,
    input  logic [$clog2(NUM_WORDS)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb rdata_d = mem_q[addr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (we && strb[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_arb.sv
// CPU/DMA shared data memory: per-cycle arbitration, misaligned CPU split FSM,
// lane shifting on stores and lane merging on loads.
module data_mem_arb
    import data_mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int NUM_WORDS       = 256,
    parameter int ARB_MODE        = 0
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    data_mem_arb_if.slave bus,
    output state_t        dbg_state
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [DATA_ADDR_WIDTH:0] DEPTH = (DATA_ADDR_WIDTH+1)'(NUM_WORDS);

    state_t                state_q, state_d;
    logic                  last_dma_q, last_dma_d;
    logic                  rvalid_q, rvalid_d, split_q, split_d;
    logic                  err_q, err_d, last_oor_q, last_oor_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [1:0]            sz_q, sz_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic                  dma_rvalid_q, dma_rvalid_d, dma_oor_q, dma_oor_d;

    logic [DATA_ADDR_WIDTH-1:0] n;
    logic [DATA_ADDR_WIDTH:0]   n1;
    logic [OFF_W-1:0]           off;
    int                         nb, rd_nb;
    logic                       misal, n_oor, n1_oor, dma_oor;
    lane_mask_t                 lm;
    logic                       unused_lm;
    logic                       cpu_win, dma_win, cpu_done;

    logic                  bank_we;
    logic [BYTES-1:0]      bank_strb;
    logic [IDX_W-1:0]      bank_addr;
    logic [DATA_WIDTH-1:0] bank_wdata, bank_rdata;
    logic [DATA_WIDTH-1:0] rd_word, rd_data;

    always_comb begin
        n       = bus.cpu_addr >> OFF_W;
        n1      = {1'b0, n} + 1'b1;
        off     = bus.cpu_addr[OFF_W-1:0];
        nb      = size_bytes(bus.cpu_size, BYTES);
        misal   = (int'(off) + nb) > BYTES;
        n_oor   = {1'b0, n} >= DEPTH;
        n1_oor  = n1 >= DEPTH;
        dma_oor = {1'b0, bus.dma_addr} >= DEPTH;
        lm      = lane_masks(BYTES, int'(off), nb);
    end

    assign unused_lm = ^lm;

    // In round-robin mode the last-winner pointer only matters on contention.
    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (state_q == IDLE) begin
            if (ARB_MODE == ARB_RR && bus.cpu_req && bus.dma_req) cpu_win = last_dma_q;
            else                                                  cpu_win = bus.cpu_req;
            dma_win = bus.dma_req && !cpu_win;
        end
        cpu_done = (cpu_win && !misal) || (state_q == SPLIT);
    end

    always_comb begin
        state_d    = state_q;
        last_dma_d = last_dma_q;
        case (state_q)
            IDLE:    if (cpu_win && misal) state_d = SPLIT;
            SPLIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cpu_win)      last_dma_d = 1'b0;
        else if (dma_win) last_dma_d = 1'b1;
    end

    // SPLIT relies on cpu_addr/cpu_wdata being held, so word n+1 is re-derived.
    always_comb begin
        bank_we    = 1'b0;
        bank_strb  = '0;
        bank_addr  = n[IDX_W-1:0];
        bank_wdata = bus.cpu_wdata << (8 * int'(off));
        if (state_q == SPLIT) begin
            bank_addr  = n1[IDX_W-1:0];
            bank_we    = bus.cpu_we && !n1_oor;
            bank_strb  = lm.p1[BYTES-1:0];
            bank_wdata = bus.cpu_wdata >> (8 * (BYTES - int'(off)));
        end else if (cpu_win) begin
            bank_we    = bus.cpu_we && !n_oor;
            bank_strb  = lm.p0[BYTES-1:0];
        end else if (dma_win) begin
            bank_addr  = bus.dma_addr[IDX_W-1:0];
            bank_we    = bus.dma_we && !dma_oor;
            bank_strb  = '1;
            bank_wdata = bus.dma_wdata;
        end
    end

    always_comb begin
        rvalid_d     = 1'b0;
        split_d      = split_q;
        err_d        = err_q;
        last_oor_d   = last_oor_q;
        off_d        = off_q;
        sz_d         = sz_q;
        lo_d         = lo_q;
        dma_rvalid_d = dma_win && !bus.dma_we;
        dma_oor_d    = dma_oor;
        if (state_q == SPLIT) lo_d = n_oor ? '0 : (bank_rdata >> (8 * int'(off)));
        if (cpu_done && !bus.cpu_we) begin
            rvalid_d   = 1'b1;
            split_d    = (state_q == SPLIT);
            off_d      = off;
            sz_d       = bus.cpu_size;
            err_d      = n_oor || ((state_q == SPLIT) && n1_oor);
            last_oor_d = (state_q == SPLIT) ? n1_oor : n_oor;
        end
    end

    always_comb begin
        rd_word = last_oor_q ? '0 : bank_rdata;
        rd_data = split_q ? (lo_q | (rd_word << (8 * (BYTES - int'(off_q)))))
                          : (rd_word >> (8 * int'(off_q)));
        rd_nb   = size_bytes(sz_q, BYTES);
        for (int i = 0; i < BYTES; i++) begin
            if (i >= rd_nb) rd_data[8*i +: 8] = '0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q      <= IDLE;
            last_dma_q   <= 1'b1;
            rvalid_q     <= 1'b0;
            split_q      <= 1'b0;
            err_q        <= 1'b0;
            last_oor_q   <= 1'b0;
            off_q        <= '0;
            sz_q         <= '0;
            lo_q         <= '0;
            dma_rvalid_q <= 1'b0;
            dma_oor_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_dma_q   <= last_dma_d;
            rvalid_q     <= rvalid_d;
            split_q      <= split_d;
            err_q        <= err_d;
            last_oor_q   <= last_oor_d;
            off_q        <= off_d;
            sz_q         <= sz_d;
            lo_q         <= lo_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_oor_q    <= dma_oor_d;
        end
    end

    data_mem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS)
    ) u_bank (
        .clk   (cpu_clk),
        .rst   (cpu_rst),
        .we    (bank_we),
        .strb  (bank_strb),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    assign bus.cpu_rvalid      = rvalid_q;
    assign bus.cpu_rdata       = rvalid_q ? rd_data : '0;
    assign bus.cpu_err         = (rvalid_q && err_q) ||
                                 (!cpu_rst && cpu_done && bus.cpu_we &&
                                  (n_oor || ((state_q == SPLIT) && n1_oor)));
    assign bus.data_mem_hazard = bus.cpu_req && !cpu_done;
    assign bus.dma_gnt         = dma_win;
    assign bus.dma_rvalid      = dma_rvalid_q;
    assign bus.dma_rdata       = (dma_rvalid_q && !dma_oor_q) ? bank_rdata : '0;
    assign dbg_state           = state_q;

endmodule
